// File: rtl/hex_display_pkg.sv
// Shared widths, constants and scan state type for the multiplexed hex display.
package hex_display_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;
  localparam int ADDR_W  = 3;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {SCAN, HOLD} scan_state_t;

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to active-low 7-segment glyph; bit 0 is segment a.
module hex_decoder
  import hex_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display: one shared decoder scans a bank of digit
// registers and latches each result into a static per-digit segment register.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_DIV  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DIGIT_W-1:0]          wr_data,
  input  logic                        wr_blank,
  input  logic                        wr_blink,
  input  logic                        scan_en,
  output logic                        frame_done,
  output logic [SEG_W*NUM_DIGITS-1:0] hex
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIGIT_W-1:0]    value [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] blink;
  logic [SEG_W-1:0]      seg   [NUM_DIGITS];

  logic [ADDR_W-1:0] ptr;
  logic [DIV_W-1:0]  div_cnt;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_phase;

  scan_state_t state, next_state;
  logic        run;
  logic        tick;
  logic        last;
  logic        addr_ok;
  logic        dark;
  logic [SEG_W-1:0] dec_seg;

  assign addr_ok = ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_DIGITS));
  assign tick    = run && (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign last    = (ptr == ADDR_W'(NUM_DIGITS - 1));
  assign dark    = blank[ptr] | (blink[ptr] & blink_phase);

  hex_decoder u_decoder (
    .digit (value[ptr]),
    .seg   (dec_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= SCAN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SCAN: next_state = scan_en ? SCAN : HOLD;
      HOLD: next_state = scan_en ? SCAN : HOLD;
    endcase
  end

  // Freezing takes effect in the same cycle scan_en drops, not one cycle later.
  always_comb begin
    run = (next_state == SCAN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) value[i] <= '0;
      blank <= '1;
      blink <= '0;
    end else if (wr_en && addr_ok) begin
      value[wr_addr] <= wr_data;
      blank[wr_addr] <= wr_blank;
      blink[wr_addr] <= wr_blink;
    end
  end

  // Capture reads the pre-write register contents, so a colliding write waits a frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) seg[i] <= SEG_BLANK;
      ptr         <= '0;
      div_cnt     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= tick && last;
      if (run) begin
        div_cnt <= (div_cnt == DIV_W'(SCAN_DIV - 1)) ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
        seg[ptr] <= dark ? SEG_BLANK : dec_seg;
        ptr      <= last ? '0 : ptr + 1'b1;
        if (last) begin
          if (frame_cnt == FC_W'(BLINK_DIV - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    assign hex[SEG_W*g +: SEG_W] = seg[g];
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench: directed scenarios plus randomized traffic against a tick-counting reference model.
module tb_hex_display_scanner;

  localparam int N  = 6;
  localparam int SD = 1;
  localparam int BD = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [3:0]   wr_data = '0;
  logic         wr_blank = 1'b0;
  logic         wr_blink = 1'b0;
  logic         scan_en = 1'b1;
  logic         frame_done;
  logic [7*N-1:0] hex;

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;

  hex_display_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
    .wr_blink   (wr_blink),
    .scan_en    (scan_en),
    .frame_done (frame_done),
    .hex        (hex)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference model: scan position and blink phase derive from counts of enabled cycles and ticks.
  logic [6:0] m_seg [N];
  logic [3:0] m_val [N];
  bit         m_blank [N];
  bit         m_blink [N];
  bit         m_fd;
  int         m_en_cycles;
  int         m_ticks;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_seg[i] = 7'h7F; m_val[i] = 4'h0; m_blank[i] = 1'b1; m_blink[i] = 1'b0;
      end
      m_fd = 1'b0; m_en_cycles = 0; m_ticks = 0;
    end else begin
      m_fd = 1'b0;
      if (scan_en) begin
        if ((m_en_cycles % SD) == SD - 1) begin
          int p;
          bit phase;
          p = m_ticks % N;
          phase = (((m_ticks / N) / BD) % 2) == 1;
          m_seg[p] = (m_blank[p] || (m_blink[p] && phase)) ? 7'h7F : glyph(m_val[p]);
          if (p == N - 1) m_fd = 1'b1;
          m_ticks++;
        end
        m_en_cycles++;
      end
      if (wr_en && wr_addr < N) begin
        m_val[wr_addr]   = wr_data;
        m_blank[wr_addr] = wr_blank;
        m_blink[wr_addr] = wr_blink;
      end
    end
  end

  always @(negedge clock) begin
    if (check_on) begin
      logic [7*N-1:0] exp_hex;
      for (int i = 0; i < N; i++) exp_hex[7*i +: 7] = m_seg[i];
      checks++;
      if (hex !== exp_hex || frame_done !== m_fd) begin
        errors++;
        $display("[TB] FAIL model t=%0t hex=%h frame_done=%b expected hex=%h frame_done=%b",
                 $time, hex, frame_done, exp_hex, m_fd);
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [6:0] digit(input int i);
    return hex[7*i +: 7];
  endfunction

  task automatic apply_write(input logic [2:0] a, input logic [3:0] d, input logic b, input logic k);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_blank = b; wr_blink = k;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_ptr(input int p);
    int guard = 0;
    while ((m_ticks % N) != p && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check_output("wait_ptr_timeout", 64'(guard >= 50), 64'd0);
  endtask

  task automatic wait_frame();
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!frame_done && guard < 20);
    check_output("wait_frame_timeout", 64'(frame_done), 64'd1);
  endtask

  initial begin
    int fd_count;
    int lat;
    logic [6:0] seq [8];
    logic [7*N-1:0] all_dark;
    all_dark = '1;

    // Reset state
    repeat (3) @(negedge clock);
    check_output("reset_hex", 64'(hex), 64'(all_dark));
    check_output("reset_frame_done", 64'(frame_done), 64'd0);
    check_output("glyph_pin_0", 64'(glyph(4'h0)), 64'h40);
    check_output("glyph_pin_8", 64'(glyph(4'h8)), 64'h00);
    reset = 1'b0;
    check_on = 1'b1;

    // 1: idle frames
    fd_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (frame_done) fd_count++;
      check_output("idle_hex", 64'(hex), 64'(all_dark));
    end
    check_output("idle_frame_count", 64'(fd_count), 64'd3);

    // 2: basic writes
    apply_write(3'd0, 4'h0, 1'b0, 1'b0);
    apply_write(3'd1, 4'h1, 1'b0, 1'b0);
    apply_write(3'd5, 4'hA, 1'b0, 1'b0);
    repeat (N + 1) @(negedge clock);
    check_output("digit0_0", 64'(digit(0)), 64'h40);
    check_output("digit1_1", 64'(digit(1)), 64'h79);
    check_output("digit5_A", 64'(digit(5)), 64'h08);
    check_output("digit2_dark", 64'(digit(2)), 64'h7F);
    check_output("digit4_dark", 64'(digit(4)), 64'h7F);

    // 3: write colliding with the capture of the same digit
    wait_ptr(2);
    apply_write(3'd2, 4'h8, 1'b0, 1'b0);
    check_output("collide_old", 64'(digit(2)), 64'h7F);
    lat = 1;
    while (digit(2) !== 7'h00 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check_output("collide_new", 64'(digit(2)), 64'h00);
    check_output("latency_bound", 64'(lat <= N * SD + 1), 64'd1);

    // 4: out-of-range write
    apply_write(3'd7, 4'hF, 1'b0, 1'b0);
    repeat (N + 1) @(negedge clock);
    check_output("oob_hex", 64'(hex), 64'({7'h08, 7'h7F, 7'h7F, 7'h00, 7'h79, 7'h40}));

    // 5: blinking digit
    apply_write(3'd3, 4'hF, 1'b0, 1'b1);
    wait_frame();
    wait_frame();
    for (int f = 0; f < 8; f++) begin
      wait_frame();
      seq[f] = digit(3);
    end
    fd_count = 0;
    for (int f = 0; f < 8; f++) begin
      check_output("blink_glyph", 64'(seq[f] == 7'h0E || seq[f] == 7'h7F), 64'd1);
      if (seq[f] == 7'h0E) fd_count++;
    end
    for (int f = 0; f < 6; f++) check_output("blink_period", 64'(seq[f] != seq[f+2]), 64'd1);
    check_output("blink_lit_frames", 64'(fd_count), 64'd4);

    // 6: freeze, write, resume, then reset mid-frame
    wait_ptr(4);
    scan_en = 1'b0;
    apply_write(3'd4, 4'h1, 1'b0, 1'b0);
    fd_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (frame_done) fd_count++;
      check_output("hold_digit4", 64'(digit(4)), 64'h7F);
      check_output("hold_digit5", 64'(digit(5)), 64'h08);
    end
    check_output("hold_no_frame", 64'(fd_count), 64'd0);
    scan_en = 1'b1;
    @(negedge clock);
    check_output("resume_digit4", 64'(digit(4)), 64'h79);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_output("midreset_hex", 64'(hex), 64'(all_dark));
    check_output("midreset_frame_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!frame_done && lat < 20);
    check_output("restart_frame_cycles", 64'(lat), 64'(N * SD));

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      wr_blank = ($urandom_range(0, 3) == 0);
      wr_blink = ($urandom_range(0, 2) == 0);
      scan_en  = ($urandom_range(0, 7) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      @(negedge clock);
    end
    wr_en = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
